// File: rtl/vga_pattern_core_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_core_if
// Description : Config/scroll handshake bundle for vga_pattern_core.
//               master: the side that offers config words and scroll strobes.
//               slave : the pattern core, which returns cfg_ready.
//   cfg_in[7:0]     config word (freeze | mode[2:0] | div[1:0] | primary[1:0])
//   cfg_valid       config offer
//   cfg_ready       core can accept a config this cycle
//   scroll_in[7:0]  new vertical offset
//   scroll_valid    scroll strobe
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_pattern_core_if;
  logic [7:0] cfg_in;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] scroll_in;
  logic       scroll_valid;

  modport master (
    output cfg_in, cfg_valid, scroll_in, scroll_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_in, cfg_valid, scroll_in, scroll_valid,
    output cfg_ready
  );
endinterface
`default_nettype wire

// File: rtl/vga_pattern_core.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_core
// Description : VGA test-pattern engine. Turns beam position and blanking from
//               vga_sync into BPC-bit RGB, with a PIPE-stage output pipeline
//               (blanking delayed to match), frame-boundary config updates via
//               a valid/ready handshake, and a freezable frame counter.
// Ports       : clk, reset (sync, active-high), ena, h, v, visible,
//               hblank_in, vblank_in, frame_end, cfg_if (slave),
//               pass_in, r/g/b, hblank_o, vblank_o, t
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_core #(
  parameter int BPC  = 8,
  parameter int HW   = 10,
  parameter int VW   = 10,
  parameter int TW   = 12,
  parameter int PIPE = 1
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            ena,
  input  wire logic [HW-1:0]   h,
  input  wire logic [VW-1:0]   v,
  input  wire logic            visible,
  input  wire logic            hblank_in,
  input  wire logic            vblank_in,
  input  wire logic            frame_end,
  vga_pattern_core_if.slave    cfg_if,
  input  wire logic [BPC-1:0]  pass_in,
  output logic      [BPC-1:0]  r,
  output logic      [BPC-1:0]  g,
  output logic      [BPC-1:0]  b,
  output logic                 hblank_o,
  output logic                 vblank_o,
  output logic      [TW-1:0]   t
);

  // Wide working width: one guard bit above the widest operand so that
  // sums feeding a right shift keep their carry.
  localparam int C_MAXHV = (HW > VW) ? HW : VW;
  localparam int C_WW    = ((C_MAXHV > TW) ? C_MAXHV : TW) + 1;
  localparam int C_SW    = 3 * BPC + 2;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

  state_t     r_state;
  logic [7:0] r_active;
  logic [7:0] r_shadow;
  logic [7:0] r_voffset;
  logic [TW-1:0] r_t;

  wire logic       w_pending = (r_state == ST_PEND);
  wire logic [2:0] w_mode    = r_active[6:4];
  wire logic [1:0] w_div     = r_active[3:2];
  wire logic [1:0] w_prim    = r_active[1:0];
  wire logic       w_apply   = w_pending & frame_end;

  assign cfg_if.cfg_ready = ~w_pending & ~reset;
  assign t = r_t;

  // --------------------------------------------------------------------------
  // Config FSM, scroll register and frame counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_active  <= cfg_if.cfg_in;
      r_shadow  <= 8'd0;
      r_voffset <= 8'd0;
      r_t       <= '0;
    end else begin
      // Freeze bit comes from the config in use before any swap this cycle.
      if (frame_end && !r_active[7])
        r_t <= r_t + 1'b1;

      if (cfg_if.scroll_valid && hblank_in && (w_mode != 3'd0))
        r_voffset <= cfg_if.scroll_in;

      case (r_state)
        ST_IDLE: begin
          // An offer taken on a frame_end cycle waits for the next frame_end.
          if (cfg_if.cfg_valid) begin
            r_shadow <= cfg_if.cfg_in;
            r_state  <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (w_apply) begin
            r_active  <= r_shadow;
            r_voffset <= 8'd0;    // overrides a same-cycle scroll
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Pattern generation
  // --------------------------------------------------------------------------
  logic [VW-1:0]     w_vvn;
  logic [C_WW-1:0]   w_hx, w_vv, w_tx;
  logic [BPC-1:0]    w_a, w_bb, w_cc;
  logic [3*BPC-1:0]  w_ramp, w_pat, w_gated;
  logic              w_s, w_chk;

  always_comb begin
    w_vvn = v + VW'(r_voffset);
    w_hx  = C_WW'(h);
    w_vv  = C_WW'(w_vvn);
    w_tx  = C_WW'(r_t);
    w_a   = BPC'(w_hx >> w_div);
    w_bb  = w_vvn[BPC-1:0];
    w_cc  = r_t[BPC-1:0];
    // Bar select uses raw v: divided h in the top band, raw h below.
    w_s   = (v < VW'(256)) ? w_hx[w_div] : h[0];
    w_chk = |(((w_hx ^ w_vv) >> ({1'b0, w_div} + 3'd3)) & C_WW'(1));

    case (w_prim)
      2'd0:    w_ramp = {w_a,  w_bb, w_cc};
      2'd1:    w_ramp = {w_cc, w_a,  w_bb};
      2'd2:    w_ramp = {w_bb, w_cc, w_a};
      default: w_ramp = {w_a,  w_a,  w_a};
    endcase

    case (w_mode)
      3'd0: w_pat = {pass_in, pass_in, pass_in};
      3'd1: w_pat = w_ramp;
      3'd2: w_pat = w_ramp ^ {(3*BPC){w_s}};
      3'd4: w_pat = {BPC'(w_hx ^ w_vv),
                     BPC'(w_hx & w_vv),
                     BPC'(w_hx - w_vv + w_tx)};
      3'd5: w_pat = {BPC'(((w_hx + (w_tx >> 3)) >> 1) ^ ((w_vv + (w_tx >> 3)) >> 1)),
                     BPC'((w_hx + (w_tx >> 2)) ^ (w_vv + (w_tx >> 1))),
                     BPC'(((w_hx + (w_tx >> 1)) << 1) ^ ((w_vv + (w_tx >> 2)) << 1))};
      3'd6: w_pat = {BPC'((w_hx >> 1) ^ (w_vv >> 1)),
                     BPC'(w_hx ^ w_vv),
                     BPC'((w_hx << 1) ^ (w_vv << 1))};
      3'd7: w_pat = {(3*BPC){w_chk}};
      default: w_pat = '0;
    endcase

    w_gated = (visible && ena) ? w_pat : '0;
  end

  wire logic [C_SW-1:0] w_stage = {w_gated, hblank_in, vblank_in};

  // --------------------------------------------------------------------------
  // Output pipeline: colour and blanking travel together
  // --------------------------------------------------------------------------
  generate
    if (PIPE == 0) begin : g_pipe_comb
      assign {r, g, b, hblank_o, vblank_o} = w_stage;
    end else begin : g_pipe_reg
      logic [C_SW-1:0] r_pipe [PIPE];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_stage;
          for (int i = 1; i < PIPE; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign {r, g, b, hblank_o, vblank_o} = r_pipe[PIPE-1];
    end
  endgenerate

endmodule
`default_nettype wire
